// File: rtl/fifo_rd_stream_if.sv
// Read-port and output-stream bundle for fifo_rd_stream.
// master: the stream block (pops the FIFO, drives the stream); slave: FIFO plus downstream.
interface fifo_rd_stream_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  rempty;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  rinc;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_valid;
   logic                  out_ready;

   modport master (
      input  rempty,
      input  rdata,
      input  out_ready,
      output rinc,
      output out_data,
      output out_valid
   );

   modport slave (
      output rempty,
      output rdata,
      output out_ready,
      input  rinc,
      input  out_data,
      input  out_valid
   );
endinterface

// File: rtl/fifo_rd_stream.sv
// Async-FIFO read-side consumer: pops FWFT words into a head/skid pair and streams them out.
// Optional FIFO_RD_CNT_EN adds the rd_cnt completed-transfer counter port.
module fifo_rd_stream #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic rclk_tb,
   input  logic rrst_tb,
   fifo_rd_stream_if.master bus
`ifdef FIFO_RD_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0] rd_cnt
`endif
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_t;

   state_t                state_reg;
   state_t                state_next;
   logic [DATA_WIDTH-1:0] head_reg;
   logic [DATA_WIDTH-1:0] skid_reg;
   logic                  pop;
   logic                  drn;
   logic                  head_from_rdata;
   logic                  head_from_skid;
   logic                  skid_load;

   // Transfer depends only on registered occupancy, so there is no comb loop through out_valid.
   assign drn = (state_reg != S_EMPTY) & bus.out_ready;

   always_ff @(posedge rclk_tb or posedge rrst_tb) begin
      if (rrst_tb) begin
         state_reg <= S_EMPTY;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_EMPTY: begin
            if (pop) state_next = S_ONE;
         end
         S_ONE: begin
            if (pop && !drn)      state_next = S_TWO;
            else if (!pop && drn) state_next = S_EMPTY;
         end
         S_TWO: begin
            if (drn) state_next = S_ONE;
         end
         default: state_next = S_EMPTY;
      endcase
   end

   always_comb begin
      pop             = ~bus.rempty & (state_reg != S_TWO) & ~rrst_tb;
      bus.rinc        = pop;
      bus.out_valid   = (state_reg != S_EMPTY);
      head_from_rdata = 1'b0;
      head_from_skid  = 1'b0;
      skid_load       = 1'b0;
      case (state_reg)
         S_EMPTY: head_from_rdata = pop;
         S_ONE: begin
            head_from_rdata = pop & drn;
            skid_load       = pop & ~drn;
         end
         S_TWO:   head_from_skid = drn;
         default: ;
      endcase
   end

   always_ff @(posedge rclk_tb or posedge rrst_tb) begin
      if (rrst_tb) begin
         head_reg <= '0;
         skid_reg <= '0;
      end else begin
         if (head_from_rdata)     head_reg <= bus.rdata;
         else if (head_from_skid) head_reg <= skid_reg;
         if (skid_load)           skid_reg <= bus.rdata;
      end
   end

   assign bus.out_data = head_reg;

`ifdef FIFO_RD_CNT_EN
   logic [CNT_WIDTH-1:0] rd_cnt_reg;

   always_ff @(posedge rclk_tb or posedge rrst_tb) begin
      if (rrst_tb) begin
         rd_cnt_reg <= '0;
      end else if (drn) begin
         rd_cnt_reg <= rd_cnt_reg + CNT_WIDTH'(1);
      end
   end

   assign rd_cnt = rd_cnt_reg;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: directed and random traffic against a queue model of the FIFO and buffer.
// Build with FIFO_RD_CNT_EN defined to also check the transfer counter.
module tb_fifo_rd_stream;
   localparam int DW = 8;
   localparam int CW = 4;

   logic rclk_tb = 1'b0;
   logic rrst_tb = 1'b1;

   fifo_rd_stream_if #(.DATA_WIDTH(DW)) bus ();
`ifdef FIFO_RD_CNT_EN
   logic [CW-1:0] rd_cnt;
`endif

   fifo_rd_stream #(
      .DATA_WIDTH(DW),
      .CNT_WIDTH (CW)
   ) dut (
      .rclk_tb(rclk_tb),
      .rrst_tb(rrst_tb),
      .bus    (bus.master)
`ifdef FIFO_RD_CNT_EN
      ,
      .rd_cnt (rd_cnt)
`endif
   );

   always #5 rclk_tb = ~rclk_tb;

   int n_vec = 0;
   int n_bad = 0;
   int xfers = 0;
   int pops_seen = 0;
   logic [DW-1:0] src[$];
   logic [DW-1:0] mbuf[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic load(input int first, input int n);
      for (int i = 0; i < n; i++) src.push_back(DW'(first + i));
   endtask

   // The model: src is the FIFO contents, mbuf the words popped but not yet transferred (at most 2).
   task automatic step(input bit bubble, input bit rdy);
      logic          empty_in;
      logic          exp_rinc;
      logic          xfer;
      logic [DW-1:0] tmp;
      empty_in      = bubble || (src.size() == 0);
      bus.rempty    = empty_in;
      bus.rdata     = (src.size() != 0) ? src[0] : DW'($urandom);
      bus.out_ready = rdy;
      exp_rinc      = !empty_in && (mbuf.size() < 2);
      xfer          = (mbuf.size() != 0) && rdy;
      @(negedge rclk_tb);
      check("rinc", bus.rinc, exp_rinc);
      check("out_valid", bus.out_valid, mbuf.size() != 0);
      if (mbuf.size() != 0) check("out_data", bus.out_data, mbuf[0]);
`ifdef FIFO_RD_CNT_EN
      check("rd_cnt", rd_cnt, CW'(xfers));
`endif
      if (bus.rinc) pops_seen++;
      @(posedge rclk_tb);
      if (xfer) begin
         tmp = mbuf.pop_front();
         xfers++;
      end
      if (exp_rinc) mbuf.push_back(src.pop_front());
      #1;
   endtask

   task automatic drain(input bit with_bubbles);
      int guard = 0;
      while ((src.size() != 0 || mbuf.size() != 0) && guard < 200) begin
         step(with_bubbles ? bit'($urandom_range(0, 3) == 0) : 1'b0, 1'b1);
         guard++;
      end
      check("drain_done", src.size() + mbuf.size(), 0);
   endtask

   // Asserted a few ns after an edge so the asynchronous clear is observable between edges.
   task automatic reset_phase(input int ncyc);
      #2;
      rrst_tb = 1'b1;
      #1;
      check("rst_async_valid", bus.out_valid, 1'b0);
      check("rst_async_data", bus.out_data, 8'h00);
      mbuf.delete();
      xfers = 0;
      bus.out_ready = 1'b1;
      for (int n = 0; n < ncyc; n++) begin
         bus.rempty = 1'b0;
         bus.rdata  = (src.size() != 0) ? src[0] : 8'h11;
         @(negedge rclk_tb);
         check("rst_rinc", bus.rinc, 1'b0);
         check("rst_valid", bus.out_valid, 1'b0);
         check("rst_data", bus.out_data, 8'h00);
`ifdef FIFO_RD_CNT_EN
         check("rst_cnt", rd_cnt, 4'd0);
`endif
         @(posedge rclk_tb);
         #1;
      end
      rrst_tb = 1'b0;
   endtask

   initial begin
      bus.rempty    = 1'b0;
      bus.rdata     = 8'h11;
      bus.out_ready = 1'b0;
      @(posedge rclk_tb);
      #1;

      // Reset with a non-empty FIFO presenting 0x11
      reset_phase(4);

      // Full-rate stream
      load(8'h11, 10);
      pops_seen = 0;
      for (int i = 0; i < 12; i++) step(1'b0, 1'b1);
      check("stream_pops", pops_seen, 10);
      check("stream_xfers", xfers, 10);
`ifdef FIFO_RD_CNT_EN
      check("cnt10", rd_cnt, 4'd10);
`endif

      // Backpressure: two pops fill head+skid, then hold
      load(8'h11, 10);
      pops_seen = 0;
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
      check("bp_pops", pops_seen, 2);
      check("bp_hold", bus.out_data, 8'h11);
      check("bp_valid", bus.out_valid, 1'b1);
      for (int i = 0; i < 12; i++) begin
         step(1'b0, 1'b1);
`ifdef FIFO_RD_CNT_EN
         if (xfers == 18) check("cnt18", rd_cnt, 4'd2);
`endif
      end
      drain(1'b0);

      // rempty toggling every two cycles
      load(8'h11, 10);
      for (int i = 0; i < 24; i++) step(bit'((i / 2) % 2 == 0), 1'b1);
      drain(1'b0);

      // Reset while holding 0x11/0x12 with FIFO head 0x13
      load(8'h11, 10);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
      check("pre_rst_head", bus.out_data, 8'h11);
      reset_phase(3);
      step(1'b0, 1'b1);
      check("post_rst_head", bus.out_data, 8'h13);
      check("post_rst_valid", bus.out_valid, 1'b1);
      drain(1'b0);

      // Random bubbles, backpressure and data
      for (int i = 0; i < 400; i++) begin
         if (src.size() < 4) src.push_back(DW'($urandom));
         step(bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 2) != 0));
      end
      drain(1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
